// File: rtl/hs_arbiter_ctrl.sv
// hs_arbiter_ctrl: two-requester round-robin arbiter with four-phase req/ack handshakes on both sides.
// Build option HS_ARB_SYNC_EN: req0, req1 and out_ack pass through two-flop synchronizers first.
module hs_arbiter_ctrl #(
  parameter int DATA_W = 8,
  parameter int DELAY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              out_req,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Outputs change on the clock edge; DELAY only records the cell-library
  // propagation delay and has no cycle-level effect.
  if (DELAY < 0) begin : g_delay_invalid
  end

  logic [1:0] req_s;
  logic       ack_s;

`ifdef HS_ARB_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {out_ack, req1, req0};
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q[1:0];
  assign ack_s = sync2_q[2];
`else
  assign req_s = {req1, req0};
  assign ack_s = out_ack;
`endif

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          ack_q, ack_d;
  logic                out_req_q, out_req_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sel;

  // last_q resets to 1 so that requester 0 wins the first simultaneous request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      ack_q     <= 2'b00;
      out_req_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      out_req_q <= out_req_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    out_req_d = out_req_q;
    data_d    = data_q;
    sel       = (req_s == 2'b11) ? ~last_q : req_s[1];

    case (state_q)
      IDLE: begin
        if (req_s != 2'b00) begin
          grant_d   = sel ? 2'b10 : 2'b01;
          data_d    = sel ? data1 : data0;
          out_req_d = 1'b1;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (ack_s) begin
          out_req_d = 1'b0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (!ack_s) begin
          ack_d   = grant_q;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // The owner's own request is the only input watched here.
        if ((req_s & grant_q) == 2'b00) begin
          ack_d   = 2'b00;
          grant_d = 2'b00;
          last_d  = grant_q[1];
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign out_req  = out_req_q;
  assign out_data = data_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_hs_arbiter_ctrl.sv
// Self-checking bench for hs_arbiter_ctrl: directed scenarios plus randomized traffic
// against a transaction-level round-robin model. Honours HS_ARB_SYNC_EN for latency S.
module tb_hs_arbiter_ctrl;

`ifdef HS_ARB_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, out_req;
  logic [7:0] out_data;
  logic       out_ack = 1'b0;
  logic [1:0] grant;

  hs_arbiter_ctrl #(.DATA_W(8), .DELAY(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  // consumer: mirrors out_req onto out_ack after cons_lat extra negedges
  bit cons_auto = 1'b1;
  int cons_lat = 0;
  int cons_wait = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (cons_auto) begin
        if (out_req !== out_ack) begin
          if (cons_wait >= cons_lat) begin
            out_ack = (out_req === 1'b1);
            cons_wait = 0;
          end else begin
            cons_wait++;
          end
        end else begin
          cons_wait = 0;
        end
      end
    end
  end

  // requesters drop their request as soon as they see their ack
  initial begin
    forever begin
      @(negedge clk);
      if (ack0 === 1'b1 && req0) req0 = 1'b0;
      if (ack1 === 1'b1 && req1) req1 = 1'b0;
    end
  end

  // grant/ack event log
  typedef struct packed {
    int         t;
    logic [1:0] g;
    logic [7:0] d;
  } gev_t;
  gev_t rise_q[$];
  int   fall_q[$];
  int   ack_rises[2];
  logic [1:0] mon_g, mon_a;
  initial begin
    mon_g = 2'b00;
    mon_a = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_g = 2'b00;
        mon_a = 2'b00;
      end else begin
        if (mon_g == 2'b00 && grant != 2'b00) rise_q.push_back('{t: cyc, g: grant, d: out_data});
        if (mon_g != 2'b00 && grant == 2'b00) fall_q.push_back(cyc);
        if (!mon_a[0] && ack0 === 1'b1) ack_rises[0]++;
        if (!mon_a[1] && ack1 === 1'b1) ack_rises[1]++;
        mon_g = grant;
        mon_a = {ack1, ack0};
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    cons_lat = 0;
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!req0 && !req1 && grant === 2'b00 && ack0 === 1'b0 && ack1 === 1'b0 &&
          out_req === 1'b0 && !out_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ack0, ack1, out_req, grant} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_handshake: got ack0=%b ack1=%b out_req=%b grant=%b, required all 0", ack0, ack1, out_req, grant);
    end
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got out_data=%h, required 00", out_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset: outputs checked during asynchronous reset");
  endtask

  task automatic test_single();
    int p0, t_g, t_of, t_ar, t_af;
    cons_auto = 1'b1;
    cons_lat = 0;
    t_g = -1; t_of = -1; t_ar = -1; t_af = -1;
    @(negedge clk);
    data0 = 8'hA5;
    req0 = 1'b1;
    p0 = cyc + 1;
    for (int i = 0; i < 60 && t_af < 0; i++) begin
      @(negedge clk);
      if (t_g < 0 && grant != 2'b00) begin
        t_g = cyc;
        n_cmp++;
        if ({grant, out_req, out_data} !== {2'b01, 1'b1, 8'hA5}) begin
          n_bad++;
          $display("FAIL single_grant: got grant=%b out_req=%b out_data=%h, required 01 1 a5", grant, out_req, out_data);
        end
      end else if (t_g >= 0 && t_of < 0 && out_req === 1'b0) begin
        t_of = cyc;
      end
      if (t_ar < 0 && ack0 === 1'b1) begin
        t_ar = cyc;
      end else if (t_ar >= 0 && t_af < 0 && ack0 === 1'b0) begin
        t_af = cyc;
        n_cmp++;
        if (grant !== 2'b00) begin
          n_bad++;
          $display("FAIL single_grant_clear: got grant=%b, required 00", grant);
        end
      end
    end
    n_cmp++;
    if (t_g != p0 + S) begin
      n_bad++;
      $display("FAIL single_t_grant: got edge %0d, required %0d", t_g, p0 + S);
    end
    n_cmp++;
    if (t_of != t_g + 1 + S) begin
      n_bad++;
      $display("FAIL single_t_outreq_fall: got edge %0d, required %0d", t_of, t_g + 1 + S);
    end
    n_cmp++;
    if (t_ar != t_of + 1 + S) begin
      n_bad++;
      $display("FAIL single_t_ack_rise: got edge %0d, required %0d", t_ar, t_of + 1 + S);
    end
    n_cmp++;
    if (t_af != t_ar + 1 + S) begin
      n_bad++;
      $display("FAIL single_t_ack_fall: got edge %0d, required %0d", t_af, t_ar + 1 + S);
    end
    $display("test_single: grant@%0d outreq_fall@%0d ack_rise@%0d ack_fall@%0d", t_g, t_of, t_ar, t_af);
  endtask

  task automatic test_simultaneous();
    logic [7:0] d0, d1;
    logic [1:0] first_g [3];
    bit ok;
    first_g[0] = 2'b01; first_g[1] = 2'b01; first_g[2] = 2'b10;
    cons_auto = 1'b1;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      rise_q.delete();
      fall_q.delete();
      data0 = d0;
      data1 = d1;
      req0 = 1'b1;
      req1 = (r != 1);
      wait_idle(200, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL simul_idle_r%0d: got busy after 200 cycles, required idle", r);
      end
      n_cmp++;
      if (rise_q.size() < 1 || rise_q[0].g !== first_g[r] ||
          rise_q[0].d !== ((first_g[r] == 2'b01) ? d0 : d1)) begin
        n_bad++;
        $display("FAIL simul_first_r%0d: got %0d grants first=%b, required first=%b", r, rise_q.size(),
                 (rise_q.size() > 0) ? rise_q[0].g : 2'bxx, first_g[r]);
      end
      if (r != 1) begin
        n_cmp++;
        if (rise_q.size() != 2 || fall_q.size() < 1 || rise_q[1].g !== ~first_g[r] ||
            rise_q[1].t != fall_q[0] + 1) begin
          n_bad++;
          $display("FAIL simul_second_r%0d: got %0d grants, required second grant %b on the edge after release",
                   r, rise_q.size(), ~first_g[r]);
        end
      end
      $display("test_simultaneous: round %0d served %0d grant(s)", r, rise_q.size());
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    logic [7:0] d0, d1;
    bit ok;
    cons_auto = 1'b1;
    cons_lat = 2;
    rise_q.delete();
    fall_q.delete();
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    @(negedge clk);
    data0 = d0;
    req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (grant === 2'b01 && out_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL contention_xfer: got no grant=01 with out_req within 30 cycles, required it");
    end
    data1 = d1;
    req1 = 1'b1;
    for (int i = 0; i < 100 && grant === 2'b01; i++) begin
      @(negedge clk);
      if (grant === 2'b01) begin
        n_cmp++;
        if (ack1 !== 1'b0) begin
          n_bad++;
          $display("FAIL contention_ack1: got ack1=%b while requester 0 owns, required 0", ack1);
        end
      end
    end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL contention_idle: got busy after 200 cycles, required idle");
    end
    n_cmp++;
    if (rise_q.size() != 2 || fall_q.size() < 1 || rise_q[0].g !== 2'b01 || rise_q[1].g !== 2'b10 ||
        rise_q[1].d !== d1 || rise_q[1].t != fall_q[0] + 1) begin
      n_bad++;
      $display("FAIL contention_order: got %0d grants, required 01 then 10 (data %h) on the edge after release",
               rise_q.size(), d1);
    end
    cons_lat = 0;
    $display("test_contention: %0d grants observed", rise_q.size());
  endtask

  task automatic test_stall();
    logic [7:0] d1;
    bit ok;
    cons_auto = 1'b0;
    out_ack = 1'b0;
    rise_q.delete();
    ack_rises[0] = 0;
    ack_rises[1] = 0;
    d1 = 8'($urandom_range(1, 255));
    @(negedge clk);
    data1 = d1;
    req1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant === 2'b10) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL stall_grant: got grant=%b after 20 cycles, required 10", grant);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        data0 = 8'($urandom);
        req0 = 1'b1;
      end
      if (i == 6) req0 = 1'b0;
      n_cmp++;
      if ({out_req, grant, ack1, out_data} !== {1'b1, 2'b10, 1'b0, d1}) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got out_req=%b grant=%b ack1=%b out_data=%h, required 1 10 0 %h",
                 i, out_req, grant, ack1, out_data, d1);
      end
    end
    cons_auto = 1'b1;
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || rise_q.size() != 1 || ack_rises[0] != 0 || ack_rises[1] != 1) begin
      n_bad++;
      $display("FAIL stall_phantom: got idle=%0d grants=%0d ack0_rises=%0d ack1_rises=%0d, required 1 1 0 1",
               ok, rise_q.size(), ack_rises[0], ack_rises[1]);
    end
    $display("test_stall: 10 held cycles checked, grants=%0d", rise_q.size());
  endtask

  task automatic test_reset_drain();
    logic [7:0] d1;
    bit ok;
    cons_auto = 1'b1;
    cons_lat = 5;
    d1 = 8'($urandom_range(1, 255));
    @(negedge clk);
    data1 = d1;
    req1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant === 2'b10 && out_req === 1'b0 && ack1 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_reach: got no DRAIN with grant=10 within 40 cycles, required it");
    end
    #2 reset = 1'b1;
    req1 = 1'b0;
    cons_lat = 0;
    #1;
    n_cmp++;
    if ({ack0, ack1, out_req, grant, out_data} !== 13'b0) begin
      n_bad++;
      $display("FAIL drain_reset: got ack0=%b ack1=%b out_req=%b grant=%b out_data=%h, required all 0",
               ack0, ack1, out_req, grant, out_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rise_q.delete();
    data0 = 8'($urandom);
    data1 = 8'($urandom);
    req0 = 1'b1;
    req1 = 1'b1;
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || rise_q.size() < 1 || rise_q[0].g !== 2'b01) begin
      n_bad++;
      $display("FAIL drain_restart: got idle=%0d grants=%0d first=%b, required first grant 01",
               ok, rise_q.size(), (rise_q.size() > 0) ? rise_q[0].g : 2'bxx);
    end
    $display("test_reset_drain: reset during DRAIN checked, restart grants=%0d", rise_q.size());
  endtask

  task automatic test_random();
    int ph[2], cnt[2], vis[2];
    logic [7:0] dat[2];
    logic last_w;
    int idle_since, owner, min_vis, exp_t, w, n_tx;
    logic [1:0] prev_g, pend, exp_g, exp_a;
    bit ok;
    cons_auto = 1'b1;
    do_reset();
    idle_since = cyc;
    last_w = 1'b1;
    prev_g = 2'b00;
    owner = 0;
    n_tx = 0;
    for (int n = 0; n < 2; n++) begin
      ph[n] = 0;
      cnt[n] = $urandom_range(0, 4);
      vis[n] = 0;
      dat[n] = 8'h00;
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 40 == 0) cons_lat = $urandom_range(0, 3);
      if (prev_g == 2'b00 && grant != 2'b00) begin
        pend = 2'b00;
        min_vis = 1 << 30;
        for (int n = 0; n < 2; n++) begin
          if (ph[n] == 1) begin
            if (vis[n] < min_vis) min_vis = vis[n];
            if (vis[n] <= cyc) pend[n] = 1'b1;
          end
        end
        w = (pend == 2'b11) ? (last_w ? 0 : 1) : (pend[1] ? 1 : 0);
        exp_g = (pend == 2'b00) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
        exp_t = (idle_since + 1 > min_vis) ? idle_since + 1 : min_vis;
        n_cmp++;
        if (grant !== exp_g || out_data !== dat[w] || cyc != exp_t) begin
          n_bad++;
          $display("FAIL rand_grant: got grant=%b data=%h edge=%0d, required grant=%b data=%h edge=%0d",
                   grant, out_data, cyc, exp_g, dat[w], exp_t);
        end
        owner = w;
        n_tx++;
      end
      if (prev_g != 2'b00 && grant == 2'b00) begin
        last_w = owner[0];
        idle_since = cyc;
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        exp_a = (owner == 1) ? 2'b10 : 2'b01;
        n_cmp++;
        if ({ack1, ack0} !== exp_a) begin
          n_bad++;
          $display("FAIL rand_ack: got ack1ack0=%b%b, required %b", ack1, ack0, exp_a);
        end
      end
      prev_g = grant;
      for (int n = 0; n < 2; n++) begin
        logic r, a;
        r = (n == 1) ? req1 : req0;
        a = (n == 1) ? ack1 : ack0;
        if (ph[n] == 1 && !r) begin
          ph[n] = 0;
          cnt[n] = $urandom_range(0, 6);
        end else if (ph[n] == 0 && c < 1400) begin
          if (cnt[n] > 0) begin
            cnt[n]--;
          end else if (a === 1'b0) begin
            dat[n] = 8'($urandom);
            ph[n] = 1;
            vis[n] = cyc + 1 + S;
            if (n == 1) begin
              data1 = dat[1];
              req1 = 1'b1;
            end else begin
              data0 = dat[0];
              req0 = 1'b1;
            end
          end
        end
      end
    end
    wait_idle(300, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rand_idle: got busy after 300 cycles, required idle");
    end
    $display("test_random: %0d transactions checked against model", n_tx);
  endtask

  initial begin
    ack_rises[0] = 0;
    ack_rises[1] = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_stall();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
